// File: rtl/tdm_demux_4ch_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM encodings and slot-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_demux_4ch_pkg;

    // Frame alignment FSM encodings
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Width of a slot index for a given channel count (minimum one bit)
    function automatic int tdm_slot_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot index with increment enable and synchronous load-to-1.
// Latency: o_slot updates on the edge that samples i_en/i_load; o_last_slot is combinational from o_slot.
// Backpressure: none; holds its value whenever neither i_en nor i_load is set.
module tdm_slot_counter
    import tdm_demux_4ch_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_en,
    input  logic                            i_load,
    output logic [tdm_slot_w(CHANNELS)-1:0] o_slot,
    output logic                            o_last_slot
);

    localparam int SLOT_W = tdm_slot_w(CHANNELS);

    logic [SLOT_W-1:0] r_slot;

    // Load wins over increment: a frame-start beat always occupies slot 0, so the next one is 1.
    // CHANNELS is a power of two, so plain binary wrap gives the modulo behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot <= SLOT_W'(1);
        end else if (i_en) begin
            r_slot <= r_slot + 1'b1;
        end
    end

    assign o_slot      = r_slot;
    assign o_last_slot = (r_slot == SLOT_W'(CHANNELS - 1));

endmodule

// File: rtl/tdm_demux_4ch.sv
// Steers multiplexed beats into per-channel slots and publishes whole frames atomically.
// Latency: final beat of a frame captured on edge t appears on ch_data/frame_done right after edge t.
// Backpressure: none; din_valid low simply stalls slot advance, upstream must pace itself.
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                din,
    input  logic                            din_valid,
    input  logic                            frame_start,
    output logic [CHANNELS*WIDTH-1:0]       ch_data,
    output logic                            frame_done,
    output logic [tdm_slot_w(CHANNELS)-1:0] slot,
    output logic                            sync_err
);

    localparam int SLOT_W = tdm_slot_w(CHANNELS);

    logic [0:0]                r_state;
    logic [WIDTH-1:0]          r_shadow [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_ch_data;
    logic                      r_frame_done;
    logic                      r_sync_err;

    logic [SLOT_W-1:0]         w_slot;
    logic                      w_last_slot;
    logic                      w_load;
    logic                      w_accept;
    logic                      w_resync;
    logic                      w_complete;
    logic [CHANNELS*WIDTH-1:0] w_merged;

    // Any valid frame-start beat restarts alignment; plain beats only count while aligned.
    assign w_load     = din_valid && frame_start;
    assign w_accept   = din_valid && !frame_start && (r_state == ST_FILL);
    assign w_resync   = w_load && (r_state == ST_FILL);
    assign w_complete = w_accept && w_last_slot;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS)
    ) u_slot_counter (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_accept),
        .i_load      (w_load),
        .o_slot      (w_slot),
        .o_last_slot (w_last_slot)
    );

    // Frame as it would be published this cycle: shadow slots with the incoming beat merged at its index
    always_comb begin
        w_merged = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SLOT_W'(k) == w_slot) begin
                w_merged[k*WIDTH +: WIDTH] = din;
            end else begin
                w_merged[k*WIDTH +: WIDTH] = r_shadow[k];
            end
        end
    end

    // Alignment FSM: HUNT drops beats until a frame start, FILL returns to HUNT once the frame completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else if (w_load) begin
            r_state <= ST_FILL;
        end else if (w_complete) begin
            r_state <= ST_HUNT;
        end
    end

    // Shadow capture; a frame-start beat always lands in slot 0 regardless of the current index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_load) begin
            r_shadow[0] <= din;
        end else if (w_accept) begin
            r_shadow[w_slot] <= din;
        end
    end

    // Publish register: only ever written with a complete frame, so consumers never see a torn update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_data <= '0;
        end else if (w_complete) begin
            r_ch_data <= w_merged;
        end
    end

    // Single-cycle status pulses; completion and resync come from mutually exclusive beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= w_complete;
            r_sync_err   <= w_resync;
        end
    end

    assign ch_data    = r_ch_data;
    assign frame_done = r_frame_done;
    assign slot       = w_slot;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed frames plus randomized traffic against a queue model.
// Latency: model expects the published frame immediately after the edge that takes the final beat.
// Backpressure: din_valid gaps are exercised; the DUT has no ready signal.
module tb_tdm_demux_4ch;

    localparam int CH = 4;
    localparam int W  = 2;

    logic            clk;
    logic            rst;
    logic [W-1:0]    din;
    logic            din_valid;
    logic            frame_start;
    logic [CH*W-1:0] ch_data;
    logic            frame_done;
    logic [1:0]      slot;
    logic            sync_err;

    tdm_demux_4ch #(
        .CHANNELS (CH),
        .WIDTH    (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .ch_data     (ch_data),
        .frame_done  (frame_done),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Reference model: beats of the frame in progress, and whether we are aligned to a frame
    logic [W-1:0]    m_part [$];
    bit              m_aligned;
    logic [CH*W-1:0] m_ch;
    logic            m_done;
    logic            m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_part.delete();
            m_aligned = 1'b0;
            m_ch      = '0;
        end else if (v) begin
            if (fs) begin
                m_err = m_aligned;
                m_part.delete();
                m_part.push_back(d);
                m_aligned = 1'b1;
            end else if (m_aligned) begin
                m_part.push_back(d);
                if (m_part.size() == CH) begin
                    for (int k = 0; k < CH; k++) begin
                        m_ch[k*W +: W] = m_part[k];
                    end
                    m_done = 1'b1;
                    m_part.delete();
                    m_aligned = 1'b0;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 ns later
    task automatic step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
        @(negedge clk);
        rst         = r;
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        model_step(r, v, fs, d);
        #1;
        check("ch_data", 32'(ch_data), 32'(m_ch));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("sync_err", 32'(sync_err), 32'(m_err));
        check("slot", 32'(slot), 32'(m_part.size() % CH));
        check("done_err_excl", 32'(frame_done & sync_err), 32'd0);
        if (frame_done) done_cnt++;
        if (sync_err)   err_cnt++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    int d0;
    int e0;

    initial begin
        rst         = 1'b1;
        din         = '0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        m_aligned   = 1'b0;
        m_ch        = '0;
        m_done      = 1'b0;
        m_err       = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 2'b11);
        check("rst_ch_data", 32'(ch_data), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_pulses", 32'({frame_done, sync_err}), 32'd0);

        // Basic frame
        d0 = done_cnt;
        step(1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b0, 1'b1, 1'b0, 2'b10);
        step(1'b0, 1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        check("basic_ch", 32'(ch_data), 32'h39);
        check("basic_done", 32'(frame_done), 32'd1);
        idle();
        idle();
        check("basic_done_once", 32'(done_cnt - d0), 32'd1);

        // Stall between beats 2 and 3
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b0, 1'b1, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("stall_slot", 32'(slot), 32'd2);
            check("stall_no_done", 32'(frame_done), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        check("stall_ch", 32'(ch_data), 32'h39);
        check("stall_done", 32'(frame_done), 32'd1);

        // Resync mid-frame
        step(1'b1, 1'b0, 1'b0, '0);
        e0 = err_cnt;
        d0 = done_cnt;
        step(1'b0, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        check("resync_err", 32'(sync_err), 32'd1);
        check("resync_slot", 32'(slot), 32'd1);
        step(1'b0, 1'b1, 1'b0, 2'b10);
        step(1'b0, 1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 2'b00);
        check("resync_ch", 32'(ch_data), 32'h39);
        check("resync_err_once", 32'(err_cnt - e0), 32'd1);
        check("resync_done_once", 32'(done_cnt - d0), 32'd1);

        // Hunt discard
        step(1'b1, 1'b0, 1'b0, '0);
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, W'($urandom));
            check("hunt_slot", 32'(slot), 32'd0);
        end
        check("hunt_no_done", 32'(done_cnt - d0), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b11);
        check("hunt_ch", 32'(ch_data), 32'hFF);

        // Back-to-back frames
        step(1'b1, 1'b0, 1'b0, '0);
        d0 = done_cnt;
        e0 = err_cnt;
        step(1'b0, 1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b01);
        check("b2b_ch_a", 32'(ch_data), 32'h55);
        step(1'b0, 1'b1, 1'b1, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'b10);
            check("b2b_hold_a", 32'(ch_data), (i == 2) ? 32'hAA : 32'h55);
        end
        check("b2b_done_b", 32'(frame_done), 32'd1);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b2b_no_err", 32'(err_cnt - e0), 32'd0);

        // Reset mid-frame
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 2'b10);
        step(1'b0, 1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b0, 2'b10);
        check("midrst_ch", 32'(ch_data), 32'd0);
        check("midrst_slot", 32'(slot), 32'd0);
        check("midrst_pulses", 32'({frame_done, sync_err}), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'b10);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b10);
        check("midrst_ch_after", 32'(ch_data), 32'hAA);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
